// File: rtl/gpio_pkg.sv
// Shared constants for GPIO code receiver blocks: FSM encoding,
// LEDR field positions and the channel limit.
package gpio_pkg;
   localparam int MAX_CH = 4;

   localparam logic [0:0] S_STABLE = 1'b0;
   localparam logic [0:0] S_SETTLE = 1'b1;

   localparam int LED_SYNC_LSB = 0;
   localparam int LED_CODE_LSB = 4;
   localparam int LED_VALID    = 8;
   localparam int LED_OVR      = 9;
endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous bits,
// cleared by an asynchronous active-high reset.
module sync_bus #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/gpio_code_receiver.sv
// Receives a debounced GPIO code and hands non-zero codes to game
// logic through a valid/ack handshake with overrun and event count.
module gpio_code_receiver
   import gpio_pkg::*;
#(
   parameter int N_CH          = 3,
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = 8,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [N_CH-1:0]  gpio_in,
   input  logic             code_ack,
   output logic [N_CH-1:0]  code,
   output logic             code_valid,
   output logic             overrun,
   output logic [CNT_W-1:0] event_count,
   output logic [9:0]       LEDR
);
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   if (N_CH > MAX_CH) begin : g_nch_check
      $error("N_CH exceeds MAX_CH");
   end

   logic [N_CH-1:0]  sync_val;
   logic [0:0]       state_q, state_d;
   logic [N_CH-1:0]  cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_CH-1:0]  code_q, code_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] evt_q, evt_d;
   logic             accept;

   sync_bus #(
      .WIDTH  (N_CH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (CLOCK_50),
      .rst_i (reset),
      .d_i   (gpio_in),
      .q_o   (sync_val)
   );

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      evt_d   = evt_q;
      accept  = 1'b0;
      unique case (state_q)
         S_STABLE: begin
            if (sync_val != code_q) begin
               cand_d  = sync_val;
               cnt_d   = CNT_ONE;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (sync_val == code_q) begin
               state_d = S_STABLE;
            end else if (sync_val != cand_q) begin
               cand_d = sync_val;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               accept  = 1'b1;
               code_d  = cand_q;
               state_d = S_STABLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = S_STABLE;
      endcase
      if (code_ack && valid_q) begin
         valid_d = 1'b0;
      end
      // A zero code just means the controller went idle.
      if (accept && (cand_q != '0)) begin
         valid_d = 1'b1;
         evt_d   = evt_q + CNT_W'(1);
         if (valid_q && !code_ack) begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_STABLE;
         cand_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         evt_q   <= evt_d;
      end
   end

   always_comb begin
      LEDR = '0;
      LEDR[LED_SYNC_LSB +: N_CH] = sync_val;
      LEDR[LED_CODE_LSB +: N_CH] = code_q;
      LEDR[LED_VALID] = valid_q;
      LEDR[LED_OVR]   = ovr_q;
   end

   assign code        = code_q;
   assign code_valid  = valid_q;
   assign overrun     = ovr_q;
   assign event_count = evt_q;
endmodule

// File: tb/tb_gpio_code_receiver.sv
// Directed bench for gpio_code_receiver: debounce latency, glitches,
// handshake, overrun, restart, async reset and counter wrap.
module tb_gpio_code_receiver;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] gpio, gpio2;
   logic       ack, ack2;
   logic [2:0] code, code2;
   logic       valid, valid2;
   logic       ovr, ovr2;
   logic [7:0] cnt;
   logic [1:0] cnt2;
   logic [9:0] led, led2;

   int n_cmp = 0;
   int n_err = 0;
   int codes [5] = '{1, 2, 3, 1, 2};
   int wraps [5] = '{1, 2, 3, 0, 1};

   always #5 clk = ~clk;

   gpio_code_receiver #(
      .N_CH(3), .STABLE_CYCLES(4), .CNT_W(8), .SYNC_STAGES(2)
   ) u1 (
      .CLOCK_50(clk), .reset(rst), .gpio_in(gpio), .code_ack(ack),
      .code(code), .code_valid(valid), .overrun(ovr),
      .event_count(cnt), .LEDR(led)
   );

   gpio_code_receiver #(
      .N_CH(3), .STABLE_CYCLES(4), .CNT_W(2), .SYNC_STAGES(2)
   ) u2 (
      .CLOCK_50(clk), .reset(rst), .gpio_in(gpio2), .code_ack(ack2),
      .code(code2), .code_valid(valid2), .overrun(ovr2),
      .event_count(cnt2), .LEDR(led2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; gpio = '0; gpio2 = '0; ack = 1'b0; ack2 = 1'b0;
      edges(2);
      chk("rst_code", code, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;

      gpio = 3'b101;
      edges(2);
      gpio = 3'b000;
      edges(8);
      chk("glitch_code", code, 0);
      chk("glitch_valid", valid, 0);
      chk("glitch_cnt", cnt, 0);

      gpio = 3'b101;
      edges(5);
      chk("lat_early_code", code, 0);
      edges(1);
      chk("lat_code", code, 5);
      chk("lat_valid", valid, 1);
      chk("lat_cnt", cnt, 1);
      chk("lat_led", led, 10'h155);

      gpio = 3'b010;
      edges(6);
      chk("ovr_code", code, 2);
      chk("ovr_valid", valid, 1);
      chk("ovr_flag", ovr, 1);
      chk("ovr_cnt", cnt, 2);
      chk("ovr_led", led, 10'h322);

      rst = 1'b1;
      #1;
      chk("rst2_ovr", ovr, 0);
      chk("rst2_code", code, 0);
      @(negedge clk);
      rst = 1'b0; gpio = 3'b101;
      edges(6);
      chk("re_code", code, 5);
      chk("re_cnt", cnt, 1);

      gpio = 3'b011;
      edges(5);
      ack = 1'b1;
      edges(1);
      ack = 1'b0;
      chk("sim_code", code, 3);
      chk("sim_valid", valid, 1);
      chk("sim_ovr", ovr, 0);
      chk("sim_cnt", cnt, 2);
      ack = 1'b1;
      edges(1);
      ack = 1'b0;
      chk("ack_valid", valid, 0);
      chk("ack_code", code, 3);
      ack = 1'b1;
      edges(1);
      ack = 1'b0;
      chk("idle_ack_valid", valid, 0);
      chk("idle_ack_ovr", ovr, 0);
      chk("idle_ack_cnt", cnt, 2);

      gpio = 3'b101;
      edges(3);
      gpio = 3'b110;
      for (int i = 0; i < 5; i++) begin
         edges(1);
         chk("restart_hold", code, 3);
      end
      edges(1);
      chk("restart_code", code, 6);
      chk("restart_valid", valid, 1);
      chk("restart_cnt", cnt, 3);
      chk("restart_ovr", ovr, 0);

      gpio = 3'b001;
      edges(3);
      rst = 1'b1;
      #1;
      chk("mid_code", code, 0);
      chk("mid_valid", valid, 0);
      chk("mid_ovr", ovr, 0);
      chk("mid_cnt", cnt, 0);
      chk("mid_led", led, 0);
      @(negedge clk);
      rst = 1'b0;
      edges(5);
      chk("mid_early", code, 0);
      edges(1);
      chk("mid_code1", code, 1);
      chk("mid_cnt1", cnt, 1);

      for (int i = 0; i < 5; i++) begin
         gpio2 = 3'(codes[i]);
         edges(6);
         chk("wrap_code", code2, codes[i]);
         chk("wrap_cnt", cnt2, wraps[i]);
         ack2 = 1'b1;
         edges(1);
         ack2 = 1'b0;
         chk("wrap_ack", valid2, 0);
      end
      chk("wrap_ovr", ovr2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
